// File: rtl/l15_req_arbiter.sv
// -----------------------------------------------------------------------------
// l15_req_arbiter
//
// Shares one L1.5 transducer interface between two requesters.
//   * Request channel: round-robin grant with per-requester outstanding
//     credits. A grant is registered in IDLE and driven in BUSY, so each
//     granted request costs at least two cycles.
//   * Requests are tagged with the requester index on threadid; responses
//     are routed back by that tag.
//   * Invalidations are broadcast to both requesters. The upstream ack is
//     returned only after both requesters have acked.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rN_val/rqtype/nc/size/
//     address/data                 requester N request (held until rN_ack)
//   rN_ack                         requester N request accepted by L1.5
//   rN_rsp_val / rN_rsp_ack        requester N response handshake
//   rsp_returntype, rsp_data_0/1   shared response payload (pass-through)
//   transducer_l15_*               request to L1.5 (threadid = grant index)
//   l15_transducer_ack             L1.5 accepted the request
//   l15_transducer_val/returntype/
//     threadid/data_0/data_1       response from L1.5
//   transducer_l15_req_ack         response consumed
// -----------------------------------------------------------------------------
module l15_req_arbiter #(
  parameter int         MAX_OUT   = 2,
  parameter logic [3:0] INV_RTYPE = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_val,
  input  logic [4:0]  r0_rqtype,
  input  logic        r0_nc,
  input  logic [2:0]  r0_size,
  input  logic [39:0] r0_address,
  input  logic [63:0] r0_data,
  output logic        r0_ack,
  output logic        r0_rsp_val,
  input  logic        r0_rsp_ack,

  input  logic        r1_val,
  input  logic [4:0]  r1_rqtype,
  input  logic        r1_nc,
  input  logic [2:0]  r1_size,
  input  logic [39:0] r1_address,
  input  logic [63:0] r1_data,
  output logic        r1_ack,
  output logic        r1_rsp_val,
  input  logic        r1_rsp_ack,

  output logic [3:0]  rsp_returntype,
  output logic [63:0] rsp_data_0,
  output logic [63:0] rsp_data_1,

  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic        transducer_l15_nc,
  output logic [2:0]  transducer_l15_size,
  output logic [39:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_threadid,
  input  logic        l15_transducer_ack,

  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic        l15_transducer_threadid,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MAX_OUT_C = 2'(MAX_OUT);

  state_t     state, state_nxt;
  logic       gnt, gnt_nxt;
  logic       rr, rr_nxt;
  logic [1:0] cnt0, cnt1;
  logic [1:0] cnt0_nxt, cnt1_nxt;
  logic [1:0] inv_got, inv_got_nxt;

  logic       elig0, elig1;
  logic       rgnt_val;
  logic       inc0, inc1;
  logic       dec0, dec1;
  logic       rsp_live;
  logic       is_inv;
  logic [1:0] inv_all;

  // Credit update: increment on grant-ack, decrement on response consume.
  // Both together cancel; a decrement at zero is dropped.
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
    logic dec_ok;
    dec_ok = dec && (cnt != 2'd0);
    case ({inc, dec_ok})
      2'b10:   cnt_update = cnt + 2'd1;
      2'b01:   cnt_update = cnt - 2'd1;
      default: cnt_update = cnt;
    endcase
  endfunction

  assign elig0    = r0_val && (cnt0 < MAX_OUT_C);
  assign elig1    = r1_val && (cnt1 < MAX_OUT_C);
  assign rgnt_val = gnt ? r1_val : r0_val;

  // Payload mux follows the registered grant; only qualified by val in BUSY.
  assign transducer_l15_rqtype   = gnt ? r1_rqtype  : r0_rqtype;
  assign transducer_l15_nc       = gnt ? r1_nc      : r0_nc;
  assign transducer_l15_size     = gnt ? r1_size    : r0_size;
  assign transducer_l15_address  = gnt ? r1_address : r0_address;
  assign transducer_l15_data     = gnt ? r1_data    : r0_data;
  assign transducer_l15_threadid = gnt;

  assign rsp_returntype = l15_transducer_returntype;
  assign rsp_data_0     = l15_transducer_data_0;
  assign rsp_data_1     = l15_transducer_data_1;

  // Request FSM: next state, grant and request-side outputs.
  always_comb begin
    state_nxt          = state;
    gnt_nxt            = gnt;
    rr_nxt             = rr;
    inc0               = 1'b0;
    inc1               = 1'b0;
    r0_ack             = 1'b0;
    r1_ack             = 1'b0;
    transducer_l15_val = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          state_nxt = BUSY;
          gnt_nxt   = (elig0 && elig1) ? rr : elig1;
        end
      end
      BUSY: begin
        transducer_l15_val = rgnt_val;
        if (!rgnt_val) begin
          // Requester withdrew before acceptance: abandon without credit.
          state_nxt = IDLE;
        end else if (l15_transducer_ack) begin
          r0_ack    = ~gnt;
          r1_ack    = gnt;
          inc0      = ~gnt;
          inc1      = gnt;
          rr_nxt    = ~gnt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response routing. Gated by rst_n so outputs drop as soon as reset asserts.
  assign rsp_live = l15_transducer_val && rst_n;
  assign is_inv   = (l15_transducer_returntype == INV_RTYPE);

  always_comb begin
    r0_rsp_val             = 1'b0;
    r1_rsp_val             = 1'b0;
    transducer_l15_req_ack = 1'b0;
    dec0                   = 1'b0;
    dec1                   = 1'b0;
    inv_all                = inv_got;
    inv_got_nxt            = inv_got;
    if (rsp_live) begin
      if (is_inv) begin
        // Each requester sees valid until it has acked; upstream ack waits
        // for both.
        r0_rsp_val = ~inv_got[0];
        r1_rsp_val = ~inv_got[1];
        inv_all    = inv_got | {r1_rsp_ack & ~inv_got[1],
                                r0_rsp_ack & ~inv_got[0]};
        if (inv_all == 2'b11) begin
          transducer_l15_req_ack = 1'b1;
          inv_got_nxt            = 2'b00;
        end else begin
          inv_got_nxt = inv_all;
        end
      end else if (l15_transducer_threadid) begin
        r1_rsp_val             = 1'b1;
        transducer_l15_req_ack = r1_rsp_ack;
        dec1                   = r1_rsp_ack;
      end else begin
        r0_rsp_val             = 1'b1;
        transducer_l15_req_ack = r0_rsp_ack;
        dec0                   = r0_rsp_ack;
      end
    end
  end

  assign cnt0_nxt = cnt_update(cnt0, inc0, dec0);
  assign cnt1_nxt = cnt_update(cnt1, inc1, dec1);

  // State register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rr      <= 1'b0;
      cnt0    <= 2'd0;
      cnt1    <= 2'd0;
      inv_got <= 2'b00;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      rr      <= rr_nxt;
      cnt0    <= cnt0_nxt;
      cnt1    <= cnt1_nxt;
      inv_got <= inv_got_nxt;
    end
  end

  // A response consumed with no credit outstanding means the L1.5 returned
  // something this arbiter never issued.
  cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((dec0 && (cnt0 == 2'd0)) || (dec1 && (cnt1 == 2'd0))));

endmodule

// File: tb/tb_l15_req_arbiter.sv
module tb_l15_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_val, r0_nc, r0_ack, r0_rsp_val, r0_rsp_ack;
  logic [4:0]  r0_rqtype;
  logic [2:0]  r0_size;
  logic [39:0] r0_address;
  logic [63:0] r0_data;
  logic        r1_val, r1_nc, r1_ack, r1_rsp_val, r1_rsp_ack;
  logic [4:0]  r1_rqtype;
  logic [2:0]  r1_size;
  logic [39:0] r1_address;
  logic [63:0] r1_data;
  logic [3:0]  rsp_returntype;
  logic [63:0] rsp_data_0, rsp_data_1;
  logic        transducer_l15_val, transducer_l15_nc, transducer_l15_threadid;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        l15_transducer_ack, l15_transducer_val, l15_transducer_threadid;
  logic [3:0]  l15_transducer_returntype;
  logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
  logic        transducer_l15_req_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  l15_req_arbiter #(.MAX_OUT(2), .INV_RTYPE(4'b0011)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_val(r0_val), .r0_rqtype(r0_rqtype), .r0_nc(r0_nc), .r0_size(r0_size),
    .r0_address(r0_address), .r0_data(r0_data), .r0_ack(r0_ack),
    .r0_rsp_val(r0_rsp_val), .r0_rsp_ack(r0_rsp_ack),
    .r1_val(r1_val), .r1_rqtype(r1_rqtype), .r1_nc(r1_nc), .r1_size(r1_size),
    .r1_address(r1_address), .r1_data(r1_data), .r1_ack(r1_ack),
    .r1_rsp_val(r1_rsp_val), .r1_rsp_ack(r1_rsp_ack),
    .rsp_returntype(rsp_returntype), .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
    .transducer_l15_val(transducer_l15_val), .transducer_l15_rqtype(transducer_l15_rqtype),
    .transducer_l15_nc(transducer_l15_nc), .transducer_l15_size(transducer_l15_size),
    .transducer_l15_address(transducer_l15_address), .transducer_l15_data(transducer_l15_data),
    .transducer_l15_threadid(transducer_l15_threadid),
    .l15_transducer_ack(l15_transducer_ack),
    .l15_transducer_val(l15_transducer_val),
    .l15_transducer_returntype(l15_transducer_returntype),
    .l15_transducer_threadid(l15_transducer_threadid),
    .l15_transducer_data_0(l15_transducer_data_0),
    .l15_transducer_data_1(l15_transducer_data_1),
    .transducer_l15_req_ack(transducer_l15_req_ack)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic t,
                         input logic a0, input logic a1);
    chk1({tag, ".val"}, transducer_l15_val, v);
    if (v) chk1({tag, ".tid"}, transducer_l15_threadid, t);
    chk1({tag, ".r0_ack"}, r0_ack, a0);
    chk1({tag, ".r1_ack"}, r1_ack, a1);
  endtask

  task automatic chk_rsp(input string tag, input logic v0, input logic v1,
                         input logic rack);
    chk1({tag, ".r0_rsp_val"}, r0_rsp_val, v0);
    chk1({tag, ".r1_rsp_val"}, r1_rsp_val, v1);
    chk1({tag, ".req_ack"}, transducer_l15_req_ack, rack);
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] e0, input logic [1:0] e1);
    chkw({tag, ".cnt0"}, 64'(dut.cnt0), 64'(e0));
    chkw({tag, ".cnt1"}, 64'(dut.cnt1), 64'(e1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    r0_val = 0; r0_rqtype = 5'd0; r0_nc = 0; r0_size = 3'd0; r0_address = '0; r0_data = '0;
    r1_val = 0; r1_rqtype = 5'd0; r1_nc = 0; r1_size = 3'd0; r1_address = '0; r1_data = '0;
    r0_rsp_ack = 0; r1_rsp_ack = 0;
    l15_transducer_ack = 0;
    l15_transducer_val = 1'b1;  // response valid during reset must not leak out
    l15_transducer_returntype = 4'd0;
    l15_transducer_threadid = 1'b0;
    l15_transducer_data_0 = '0;
    l15_transducer_data_1 = '0;

    // Reset state
    tick(); tick();
    chk_req("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_rsp("rst", 1'b0, 1'b0, 1'b0);
    chk_cnt("rst", 2'd0, 2'd0);
    l15_transducer_val = 1'b0;
    rst_n = 1'b1;
    settle();

    // Single request from r0, L1.5 acks in the third BUSY cycle
    r0_val = 1'b1; r0_rqtype = 5'd1; r0_address = 40'h10_0000_0040;
    settle();
    chk_req("single_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_req("single_c1", 1'b1, 1'b0, 1'b0, 1'b0);
    chkw("single_addr", 64'(transducer_l15_address), 64'h10_0000_0040);
    chkw("single_rqtype", 64'(transducer_l15_rqtype), 64'd1);
    tick();
    chk_req("single_c2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    l15_transducer_ack = 1'b1;
    settle();
    chk_req("single_c3", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    r0_val = 1'b0; l15_transducer_ack = 1'b0;
    settle();
    chk_req("single_done", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("single_done", 2'd1, 2'd0);

    // Load return to r0 frees its credit
    l15_transducer_val = 1'b1; l15_transducer_threadid = 1'b0;
    l15_transducer_returntype = 4'b0000; r0_rsp_ack = 1'b1;
    settle();
    chk_rsp("ld0", 1'b1, 1'b0, 1'b1);
    tick();
    l15_transducer_val = 1'b0; r0_rsp_ack = 1'b0;
    settle();
    chk_cnt("ld0", 2'd0, 2'd0);

    // Single r1 request with immediate ack (rr returns to 0 afterwards)
    r1_val = 1'b1; r1_address = 40'h20_0000_0080; l15_transducer_ack = 1'b1;
    settle();
    chk_req("r1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_req("r1_busy", 1'b1, 1'b1, 1'b0, 1'b1);
    chkw("r1_addr", 64'(transducer_l15_address), 64'h20_0000_0080);
    tick();
    r1_val = 1'b0; l15_transducer_ack = 1'b0;
    settle();
    chk_cnt("r1_done", 2'd0, 2'd1);

    // Response routing to r1
    l15_transducer_val = 1'b1; l15_transducer_threadid = 1'b1;
    l15_transducer_returntype = 4'b0000;
    l15_transducer_data_0 = 64'hDEAD_BEEF; l15_transducer_data_1 = 64'h0123_4567_89AB_CDEF;
    settle();
    chk_rsp("route_wait", 1'b0, 1'b1, 1'b0);
    chkw("route_data0", rsp_data_0, 64'hDEAD_BEEF);
    chkw("route_data1", rsp_data_1, 64'h0123_4567_89AB_CDEF);
    tick();
    chk_cnt("route_wait", 2'd0, 2'd1);
    r1_rsp_ack = 1'b1;
    settle();
    chk_rsp("route_ack", 1'b0, 1'b1, 1'b1);
    tick();
    l15_transducer_val = 1'b0; r1_rsp_ack = 1'b0;
    settle();
    chk_cnt("route_done", 2'd0, 2'd0);

    // Contention with immediate ack: grants 0,1,0,1, each ack every 4 cycles
    r0_val = 1'b1; r1_val = 1'b1; l15_transducer_ack = 1'b1;
    settle();
    for (int i = 0; i < 8; i++) begin
      chk_req($sformatf("cont%0d", i), (i % 2) == 1, (i % 4) == 3,
              (i % 4) == 1, (i % 4) == 3);
      tick();
    end

    // Both at the credit limit: nothing granted
    chk_cnt("limit", 2'd2, 2'd2);
    chk_req("limit_a", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_req("limit_b", 1'b0, 1'b0, 1'b0, 1'b0);
    // Return one r1 credit; r1 is granted while r0 stays blocked
    l15_transducer_val = 1'b1; l15_transducer_threadid = 1'b1; r1_rsp_ack = 1'b1;
    settle();
    chk_rsp("limit_r1ret", 1'b0, 1'b1, 1'b1);
    tick();
    l15_transducer_val = 1'b0; r1_rsp_ack = 1'b0;
    settle();
    chk_cnt("limit_r1ret", 2'd2, 2'd1);
    chk_req("limit_k", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_req("limit_r1gnt", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    r1_val = 1'b0;
    settle();
    chk_cnt("limit_m", 2'd2, 2'd2);
    chk_req("limit_m", 1'b0, 1'b0, 1'b0, 1'b0);
    // Load return acked by r0 releases the third r0 grant
    l15_transducer_val = 1'b1; l15_transducer_threadid = 1'b0; r0_rsp_ack = 1'b1;
    settle();
    chk_rsp("limit_r0ret", 1'b1, 1'b0, 1'b1);
    tick();
    l15_transducer_val = 1'b0; r0_rsp_ack = 1'b0;
    settle();
    chk_cnt("limit_n", 2'd1, 2'd2);
    chk_req("limit_n", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_req("limit_r0gnt", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    r0_val = 1'b0; l15_transducer_ack = 1'b0;
    settle();
    chk_cnt("limit_done", 2'd2, 2'd2);

    // Invalidation with staggered acks: r0 in cycle 1, r1 in cycle 3
    l15_transducer_val = 1'b1; l15_transducer_returntype = 4'b0011;
    l15_transducer_threadid = 1'b0; r0_rsp_ack = 1'b1;
    settle();
    chk_rsp("inv_c1", 1'b1, 1'b1, 1'b0);
    tick();
    r0_rsp_ack = 1'b0;
    settle();
    chk_rsp("inv_c2", 1'b0, 1'b1, 1'b0);
    tick();
    r1_rsp_ack = 1'b1;
    settle();
    chk_rsp("inv_c3", 1'b0, 1'b1, 1'b1);
    tick();
    l15_transducer_val = 1'b0; r1_rsp_ack = 1'b0;
    settle();
    chk_rsp("inv_idle", 1'b0, 1'b0, 1'b0);
    chk_cnt("inv_done", 2'd2, 2'd2);

    // Invalidation with simultaneous acks, then a fresh one sees cleared state
    l15_transducer_val = 1'b1; r0_rsp_ack = 1'b1; r1_rsp_ack = 1'b1;
    settle();
    chk_rsp("inv_both", 1'b1, 1'b1, 1'b1);
    tick();
    r0_rsp_ack = 1'b0; r1_rsp_ack = 1'b0;
    settle();
    chk_rsp("inv_next", 1'b1, 1'b1, 1'b0);
    l15_transducer_val = 1'b0;
    tick();
    chk_cnt("inv_both_done", 2'd2, 2'd2);

    // Async reset while BUSY
    l15_transducer_val = 1'b1; l15_transducer_returntype = 4'b0000;
    l15_transducer_threadid = 1'b1; r1_rsp_ack = 1'b1;
    settle();
    tick();
    l15_transducer_val = 1'b0; r1_rsp_ack = 1'b0; r1_val = 1'b1;
    settle();
    chk_req("rb_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    l15_transducer_ack = 1'b1;
    settle();
    chk_req("rb_busy", 1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    settle();
    chk_req("rb_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("rb_rst", 2'd0, 2'd0);
    l15_transducer_ack = 1'b0; r0_val = 1'b1;
    tick();
    rst_n = 1'b1;
    settle();
    chk_req("rb_release", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_req("rb_first", 1'b1, 1'b0, 1'b0, 1'b0);
    r0_val = 1'b0; r1_val = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
